// File: rtl/sr_button_ctrl_if.sv
// Button/command bundle between the button front panel and sr_button_ctrl.
// The master drives the raw buttons; the slave (the controller) drives the SR commands.
interface sr_button_ctrl_if;
    logic btn_set_raw;
    logic btn_rst_raw;
    logic s;
    logic r;
    logic conflict;

    modport master (
        output btn_set_raw,
        output btn_rst_raw,
        input  s,
        input  r,
        input  conflict
    );

    modport slave (
        input  btn_set_raw,
        input  btn_rst_raw,
        output s,
        output r,
        output conflict
    );
endinterface

// File: rtl/sr_button_ctrl.sv
// Synchronizes and debounces two push buttons and drives a downstream SR flip-flop,
// with reset taking priority. Define SR_BTN_LEVEL_MODE_EN for level outputs instead of pulses.
module sr_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic            clk,
    input logic            reset_n,
    sr_button_ctrl_if.slave bus
);
    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Channel 0 = set, channel 1 = reset.
    logic [1:0] raw;
    logic [1:0] deb;

    assign raw = {bus.btn_rst_raw, bus.btn_set_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic          sync1_q;
        logic          sync2_q;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          deb_q;
        logic          deb_d;

        // Reaching the final count toggles the level and leaves the counter cleared.
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d = ~deb_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                cnt_q   <= '0;
                deb_q   <= 1'b0;
            end else begin
                sync1_q <= raw[ch];
                sync2_q <= sync1_q;
                cnt_q   <= cnt_d;
                deb_q   <= deb_d;
            end
        end

        assign deb[ch] = deb_q;
    end

    logic s_d;
    logic r_d;
    logic conflict_d;
    logic s_q;
    logic r_q;
    logic conflict_q;

`ifdef SR_BTN_LEVEL_MODE_EN
    always_comb begin
        s_d        = deb[0] & ~deb[1];
        r_d        = deb[1];
        conflict_d = deb[0] & deb[1];
    end
`else
    logic [1:0] deb_prev_q;
    logic [1:0] req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev_q <= '0;
        end else begin
            deb_prev_q <= deb;
        end
    end

    assign req = deb & ~deb_prev_q;

    // A set request colliding with a reset request is dropped, never replayed.
    always_comb begin
        s_d        = req[0] & ~req[1];
        r_d        = req[1];
        conflict_d = req[0] & req[1];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.conflict = conflict_q;
endmodule
